// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue/response sequencer between EX and the iterative multiplier
// Optional one-entry result reuse cache is built when MUL_REUSE_EN is defined.
module mul_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  req_op_a_i,
  input  logic [XLEN-1:0]  req_op_b_i,
  input  logic [1:0]       req_func_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_result_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             mul_start_o,
  output logic [XLEN-1:0]  mul_op_a_o,
  output logic [XLEN-1:0]  mul_op_b_o,
  output logic [1:0]       mul_func_o,
  input  logic [XLEN-1:0]  mul_result_i,
  input  logic             mul_done_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [1:0]       func_q, func_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             fire;
  logic             done_keep;
  logic             hit;
  logic [XLEN-1:0]  hit_result;

  assign req_ready_o = (state_q == S_IDLE) && !flush_i;
  assign fire        = req_valid_i && req_ready_o;
  // A completion is kept only when it arrives in BUSY without a same-cycle flush.
  assign done_keep   = (state_q == S_BUSY) && mul_done_i && !flush_i;

`ifdef MUL_REUSE_EN
  logic [XLEN-1:0] c_a_q, c_a_d;
  logic [XLEN-1:0] c_b_q, c_b_d;
  logic [1:0]      c_func_q, c_func_d;
  logic [XLEN-1:0] c_res_q, c_res_d;
  logic            c_vld_q, c_vld_d;

  assign hit        = c_vld_q && (req_op_a_i == c_a_q) && (req_op_b_i == c_b_q) &&
                      (req_func_i == c_func_q);
  assign hit_result = c_res_q;

  always_comb begin
    c_a_d    = c_a_q;
    c_b_d    = c_b_q;
    c_func_d = c_func_q;
    c_res_d  = c_res_q;
    c_vld_d  = c_vld_q;
    if (done_keep) begin
      c_a_d    = op_a_q;
      c_b_d    = op_b_q;
      c_func_d = func_q;
      c_res_d  = mul_result_i;
      c_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_a_q    <= '0;
      c_b_q    <= '0;
      c_func_q <= '0;
      c_res_q  <= '0;
      c_vld_q  <= 1'b0;
    end else begin
      c_a_q    <= c_a_d;
      c_b_q    <= c_b_d;
      c_func_q <= c_func_d;
      c_res_q  <= c_res_d;
      c_vld_q  <= c_vld_d;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    func_d      = func_q;
    tag_d       = tag_q;
    result_d    = result_q;
    mul_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          op_a_d = req_op_a_i;
          op_b_d = req_op_b_i;
          func_d = req_func_i;
          tag_d  = req_tag_i;
          if (hit) begin
            result_d = hit_result;
            state_d  = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          mul_start_o = 1'b1;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        // The multiplier cannot be aborted, so a flush without done must drain it.
        if (flush_i) begin
          state_d = mul_done_i ? S_IDLE : S_DRAIN;
        end else if (mul_done_i) begin
          result_d = mul_result_i;
          state_d  = S_RESP;
        end
      end
      S_DRAIN: begin
        if (mul_done_i) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush_i || resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      func_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      func_q   <= func_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign stall_o       = (state_q != S_IDLE);
  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_result_o = result_q;
  assign resp_tag_o    = tag_q;
  assign mul_op_a_o    = op_a_q;
  assign mul_op_b_o    = op_b_q;
  assign mul_func_o    = func_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - randomized and directed bench for mul_issue_ctrl
// Transaction-level model plus multiplier stand-in; reuse checks built when MUL_REUSE_EN is defined.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_func;
  logic [4:0]  req_tag;
  logic        flush, stall, resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        mul_start;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [1:0]  mul_func;
  logic        mul_done;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_a_i(req_a), .req_op_b_i(req_b), .req_func_i(req_func), .req_tag_i(req_tag),
    .flush_i(flush), .stall_o(stall),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_tag_o(resp_tag),
    .mul_start_o(mul_start), .mul_op_a_o(mul_a), .mul_op_b_o(mul_b), .mul_func_o(mul_func),
    .mul_result_i(mul_result), .mul_done_i(mul_done)
  );

`ifdef MUL_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference product: extend operands to 64 bits by signedness, take low or high word.
  function automatic logic [31:0] mulfn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] f);
    logic [63:0] ea, eb, p;
    ea = {((f == 2'b01) || (f == 2'b11)) ? {32{a[31]}} : 32'd0, a};
    eb = {(f == 2'b01) ? {32{b[31]}} : 32'd0, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Transaction-level model: one outstanding op and its progress flags.
  bit          m_busy, m_need_start, m_in_mul, m_killed, m_resp;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_f;
  logic [4:0]  m_tag;
  bit          c_vld;
  logic [31:0] c_a, c_b, c_res;
  logic [1:0]  c_f;

  // Multiplier stand-in.
  bit          mb_busy;
  int          mb_cnt;
  logic [31:0] mb_a, mb_b;
  logic [1:0]  mb_f;
  int          lat_force;
  bit          spur_en, force_spur;

  logic        o_req_ready, o_resp_valid, o_start, o_stall, o_done;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  int          n_starts = 0;

  task automatic model_reset();
    m_busy = 0; m_need_start = 0; m_in_mul = 0; m_killed = 0; m_resp = 0;
    m_a = '0; m_b = '0; m_f = '0; m_tag = '0; m_res = '0;
    c_vld = 0; c_a = '0; c_b = '0; c_f = '0; c_res = '0;
  endtask

  task automatic cycle();
    bit fire;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      mb_busy = 0;
    end
    o_req_ready = req_ready; o_resp_valid = resp_valid; o_start = mul_start;
    o_stall = stall; o_result = resp_result; o_tag = resp_tag; o_done = mul_done;
    if (mul_start === 1'b1) n_starts++;
    chk("req_ready", req_ready, !m_busy && !flush);
    chk("stall", stall, m_busy);
    chk("resp_valid", resp_valid, m_resp);
    chk("mul_start", mul_start, m_need_start && !flush);
    chk("mul_op_a", mul_a, m_a);
    chk("mul_op_b", mul_b, m_b);
    chk("mul_func", mul_func, m_f);
    if (m_resp) begin
      chk("resp_result", resp_result, m_res);
      chk("resp_tag", resp_tag, m_tag);
    end
    if (mb_busy) begin
      chk("hold_a", mul_a, mb_a);
      chk("hold_b", mul_b, mb_b);
      chk("hold_func", mul_func, mb_f);
    end
    if (rst_n) begin
      if (mb_busy && mul_done) mb_busy = 0;
      if (mul_start === 1'b1) begin
        mb_busy = 1; mb_a = mul_a; mb_b = mul_b; mb_f = mul_func;
        mb_cnt = (lat_force != 0) ? lat_force : int'($urandom_range(1, 12));
      end
      fire = req_valid && !m_busy && !flush;
      if (!m_busy) begin
        if (fire) begin
          m_a = req_a; m_b = req_b; m_f = req_func; m_tag = req_tag; m_busy = 1;
          if (REUSE && c_vld && req_a == c_a && req_b == c_b && req_func == c_f) begin
            m_resp = 1; m_res = c_res;
          end else begin
            m_need_start = 1;
          end
        end
      end else if (m_need_start) begin
        m_need_start = 0;
        if (flush) m_busy = 0;
        else m_in_mul = 1;
      end else if (m_in_mul) begin
        if (mul_done) begin
          m_in_mul = 0;
          if (flush || m_killed) begin
            m_busy = 0; m_killed = 0;
          end else begin
            m_res = mulfn(m_a, m_b, m_f); m_resp = 1;
            c_vld = 1; c_a = m_a; c_b = m_b; c_f = m_f; c_res = m_res;
          end
        end else if (flush) begin
          m_killed = 1;
        end
      end else if (m_resp) begin
        if (flush || resp_ready) begin
          m_resp = 0; m_busy = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    mul_done = 1'b0;
    mul_result = $urandom;
    if (rst_n && mb_busy) begin
      mb_cnt--;
      if (mb_cnt == 0) begin
        mul_done = 1'b1;
        mul_result = mulfn(mb_a, mb_b, mb_f);
      end
    end else if (rst_n && !m_in_mul && (force_spur || (spur_en && $urandom_range(0, 7) == 0))) begin
      mul_done = 1'b1;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                       input logic [4:0] tag);
    bit fired = 0;
    req_valid = 1; req_a = a; req_b = b; req_func = f; req_tag = tag;
    for (int i = 0; i < 50 && !fired; i++) begin
      cycle();
      fired = o_req_ready;
    end
    chk("issue_fire", fired, 1);
    req_valid = 0; req_a = $urandom; req_b = $urandom;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                        input logic [4:0] tag, input logic [31:0] exp, input bit exp_hit,
                        input string nm);
    int s0;
    bit got;
    resp_ready = 1; flush = 0;
    issue(a, b, f, tag);
    s0 = n_starts;
    cycle();
    chk({nm, "_stall"}, o_stall, 1);
    chk({nm, "_t1"}, exp_hit ? o_resp_valid : o_start, 1);
    got = o_resp_valid;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = o_resp_valid;
    end
    chk({nm, "_resp"}, got, 1);
    chk({nm, "_result"}, o_result, exp);
    chk({nm, "_tag"}, o_tag, tag);
    chk({nm, "_starts"}, n_starts - s0, exp_hit ? 0 : 1);
    cycle();
    chk({nm, "_idle"}, o_stall, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int s0;
    bit got, any_resp, saw_done, fired;
    rst_n = 0; req_valid = 0; req_a = '0; req_b = '0; req_func = '0; req_tag = '0;
    flush = 0; resp_ready = 0; mul_done = 0; mul_result = '0;
    lat_force = 0; spur_en = 0; force_spur = 0; mb_busy = 0; mb_cnt = 0;
    mb_a = '0; mb_b = '0; mb_f = '0;
    model_reset();

    chk("model_mul", mulfn(32'd3, 32'hFFFFFFFB, 2'b00), 32'hFFFFFFF1);
    chk("model_mulhu", mulfn(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10), 32'hFFFFFFFE);
    chk("model_mulhsu", mulfn(32'hFFFFFFFF, 32'd2, 2'b11), 32'hFFFFFFFF);
    chk("model_mulh", mulfn(32'h80000000, 32'h80000000, 2'b01), 32'h40000000);

    repeat (3) cycle();
    chk("rst_ready", o_req_ready, 1);
    chk("rst_stall", o_stall, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_result", o_result, 0);
    rst_n = 1;
    cycle();

    run_op(32'd3, 32'hFFFFFFFB, 2'b00, 5'd9, 32'hFFFFFFF1, 0, "t1_mul");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 5'd4, 32'hFFFFFFFE, 0, "t2_mulhu");
    run_op(32'hFFFFFFFF, 32'd2, 2'b11, 5'd17, 32'hFFFFFFFF, 0, "t2_mulhsu");

    // Back-pressured response held for five cycles.
    resp_ready = 0;
    issue(32'd7, 32'd6, 2'b00, 5'd3);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = o_resp_valid;
    end
    chk("t3_resp", got, 1);
    chk("t3_result0", o_result, 42);
    req_valid = 1; req_a = 32'd11; req_b = 32'd13; req_func = 2'b00; req_tag = 5'd1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_hold_valid", o_resp_valid, 1);
      chk("t3_hold_result", o_result, 42);
      chk("t3_hold_tag", o_tag, 3);
      chk("t3_ready_low", o_req_ready, 0);
    end
    req_valid = 0; resp_ready = 1;
    cycle();
    cycle();
    chk("t3_idle", o_stall, 0);

    // Flush during START.
    issue(32'd9, 32'd9, 2'b00, 5'd2);
    flush = 1; s0 = n_starts;
    cycle();
    chk("t4_start_kill", o_start, 0);
    flush = 0;
    cycle();
    chk("t4_idle", o_stall, 0);
    any_resp = 0;
    repeat (15) begin cycle(); any_resp |= o_resp_valid; end
    chk("t4_no_resp", any_resp, 0);
    chk("t4_no_start", n_starts - s0, 0);

    // Flush ten cycles into BUSY, then drain.
    lat_force = 25;
    issue(32'd21, 32'd2, 2'b00, 5'd6);
    cycle();
    repeat (10) cycle();
    flush = 1;
    cycle();
    flush = 0; lat_force = 0;
    req_valid = 1; req_a = 32'd5; req_b = 32'd5; req_func = 2'b00; req_tag = 5'd8;
    any_resp = 0; saw_done = 0; fired = 0;
    for (int i = 0; i < 60 && !fired; i++) begin
      cycle();
      any_resp |= o_resp_valid;
      fired = o_req_ready;
      if (fired) chk("t4_fire_after_done", saw_done, 1);
      saw_done |= o_done;
    end
    chk("t4_drain_fire", fired, 1);
    chk("t4_drain_no_resp", any_resp, 0);
    req_valid = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin cycle(); got = o_resp_valid; end
    chk("t4_next_result", o_result, 25);
    cycle();

    // Spurious done while idle.
    force_spur = 1;
    cycle();
    force_spur = 0;
    cycle();
    cycle();
    chk("t5_spur_stall", o_stall, 0);
    chk("t5_spur_resp", o_resp_valid, 0);

`ifdef MUL_REUSE_EN
    run_op(32'h80000000, 32'h80000000, 2'b01, 5'd12, 32'h40000000, 0, "t6_first");
    run_op(32'h80000000, 32'h80000000, 2'b01, 5'd13, 32'h40000000, 1, "t6_hit");
    run_op(32'h80000000, 32'h80000000, 2'b00, 5'd14, 32'h00000000, 0, "t6_miss");
`endif

    // Asynchronous reset in the middle of an operation.
    lat_force = 20;
    issue(32'd100, 32'd3, 2'b00, 5'd5);
    repeat (4) cycle();
    rst_n = 0;
    #1;
    chk("async_rst_stall", stall, 0);
    cycle();
    rst_n = 1; lat_force = 0;
    cycle();

    // Randomized traffic; operands change every cycle, repeats exercise reuse.
    spur_en = 1;
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        req_a = m_a; req_b = m_b; req_func = m_f;
      end else begin
        req_a = $urandom; req_b = $urandom; req_func = 2'($urandom_range(0, 3));
      end
      req_tag = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 15) == 0);
      resp_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
